// File: rtl/rf_wb_arbiter_if.sv
// ============================================================================
// Module : rf_wb_arbiter_if
// Brief  : Writeback, long-latency result, decode and register-file signals
//          shared by the writeback arbiter and its neighbours.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface rf_wb_arbiter_if;
  logic        core_wren_i;
  logic [4:0]  core_rd_addr_i;
  logic [31:0] core_rd_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_addr_i;
  logic [31:0] lsu_rd_data_i;
  logic        issue_valid_i;
  logic [4:0]  dec_rs1_addr_i;
  logic [4:0]  dec_rs2_addr_i;
  logic [4:0]  dec_rd_addr_i;
  logic        core_stall_o;
  logic        rf_wren_o;
  logic [4:0]  rf_rd_addr_o;
  logic [31:0] rf_rd_data_o;
  logic [31:0] busy_o;

  modport master (
    output core_wren_i, core_rd_addr_i, core_rd_data_i,
    output lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
    output issue_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i,
    input  lsu_ready_o, core_stall_o, rf_wren_o, rf_rd_addr_o, rf_rd_data_o, busy_o
  );

  modport slave (
    input  core_wren_i, core_rd_addr_i, core_rd_data_i,
    input  lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
    input  issue_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i,
    output lsu_ready_o, core_stall_o, rf_wren_o, rf_rd_addr_o, rf_rd_data_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module : rf_wb_arbiter
// Brief  : Shares the register-file write port between core writeback and a
//          FIFO of long-latency results; keeps a busy scoreboard and stalls.
//          Optional same-cycle result bypass: define RF_WB_BYPASS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  rf_wb_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WAIT + 1);

  localparam logic [0:0] NORMAL = 1'b0;
  localparam logic [0:0] FORCE  = 1'b1;

  logic [4:0]    mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] wait_cnt;
  logic [0:0]    state;
  logic [0:0]    state_next;
  logic [31:0]   busy;
  logic [31:0]   busy_next;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;

  logic        empty;
  logic        full;
  logic        core_req;
  logic        accept;
  logic        bypass;
  logic        push;
  logic        pop;
  logic        blocked;
  logic        stall;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  // Extra MSB on the pointers separates full from empty.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_addr = mem_addr[rd_ptr[AW-1:0]];
  assign head_data = mem_data[rd_ptr[AW-1:0]];

  assign core_req = bus.core_wren_i && (bus.core_rd_addr_i != 5'd0);
  assign accept   = bus.lsu_valid_i && !full;

`ifdef RF_WB_BYPASS_EN
  assign bypass = empty && !core_req && (state == NORMAL) && accept &&
                  (bus.lsu_rd_addr_i != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // rd=0 results are accepted but never stored.
  assign push = accept && (bus.lsu_rd_addr_i != 5'd0) && !bypass;

  always_comb begin
    pop     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = 32'd0;
    if (state == FORCE) begin
      pop     = !empty;
      wr_en   = !empty;
      wr_addr = head_addr;
      wr_data = head_data;
    end else if (core_req) begin
      wr_en   = 1'b1;
      wr_addr = bus.core_rd_addr_i;
      wr_data = bus.core_rd_data_i;
    end else if (!empty) begin
      pop     = 1'b1;
      wr_en   = 1'b1;
      wr_addr = head_addr;
      wr_data = head_data;
    end else if (bypass) begin
      wr_en   = 1'b1;
      wr_addr = bus.lsu_rd_addr_i;
      wr_data = bus.lsu_rd_data_i;
    end
  end

  assign blocked = (state == NORMAL) && !empty && core_req;

  always_comb begin
    state_next = state;
    case (state)
      NORMAL:  if (blocked && (wait_cnt == CW'(MAX_WAIT - 1))) state_next = FORCE;
      FORCE:   state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  assign stall = (state == FORCE) || busy[bus.dec_rs1_addr_i] ||
                 busy[bus.dec_rs2_addr_i] || busy[bus.dec_rd_addr_i];

  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (bus.issue_valid_i && !stall && (bus.dec_rd_addr_i != 5'd0))
      set_mask = 32'd1 << bus.dec_rd_addr_i;
    if (pop)
      clr_mask = 32'd1 << head_addr;
    else if (bypass)
      clr_mask = 32'd1 << bus.lsu_rd_addr_i;
    busy_next = ((busy & ~clr_mask) | set_mask) & ~32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wait_cnt <= '0;
      state    <= NORMAL;
      busy     <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop || empty)
        wait_cnt <= '0;
      else if (blocked)
        wait_cnt <= wait_cnt + 1'b1;
      state <= state_next;
      busy  <= busy_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_addr[wr_ptr[AW-1:0]] <= bus.lsu_rd_addr_i;
      mem_data[wr_ptr[AW-1:0]] <= bus.lsu_rd_data_i;
    end
  end

  assign bus.lsu_ready_o  = !full;
  assign bus.core_stall_o = stall;
  assign bus.rf_wren_o    = wr_en;
  assign bus.rf_rd_addr_o = wr_addr;
  assign bus.rf_rd_data_o = wr_data;
  assign bus.busy_o       = busy;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module : tb_rf_wb_arbiter
// Brief  : Directed scoreboard bench for rf_wb_arbiter (DEPTH=4, MAX_WAIT=8).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.core_wren_i    = 1'b0;
    bus.core_rd_addr_i = 5'd0;
    bus.core_rd_data_i = 32'd0;
    bus.lsu_valid_i    = 1'b0;
    bus.lsu_rd_addr_i  = 5'd0;
    bus.lsu_rd_data_i  = 32'd0;
    bus.issue_valid_i  = 1'b0;
    bus.dec_rs1_addr_i = 5'd0;
    bus.dec_rs2_addr_i = 5'd0;
    bus.dec_rd_addr_i  = 5'd0;
  endtask

  task automatic send_result(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    bus.lsu_valid_i   = 1'b1;
    bus.lsu_rd_addr_i = a;
    bus.lsu_rd_data_i = d;
    e.addr = a;
    e.data = d;
    if (a != 5'd0) exp_q.push_back(e);
  endtask

  task automatic core_write(input logic on);
    bus.core_wren_i    = on;
    bus.core_rd_addr_i = 5'd3;
    bus.core_rd_data_i = 32'h0000_0033;
  endtask

  // The register file must never see a write to x0.
  always @(negedge clk) begin
    if (rst_n && bus.rf_wren_o && bus.rf_rd_addr_o == 5'd0) begin
      n_checks++;
      $display("FAIL x0_write got wren=1 addr=0 required no write");
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy_o, bus.lsu_ready_o, bus.core_stall_o, bus.rf_wren_o} !== {32'd0, 3'b100})
      $display("FAIL reset_state got busy=%h rdy=%b stall=%b wren=%b required 0/1/0/0",
               bus.busy_o, bus.lsu_ready_o, bus.core_stall_o, bus.rf_wren_o);
    else n_pass++;
    step();
    core_write(1'b1);
    bus.issue_valid_i = 1'b1;
    bus.dec_rd_addr_i = 5'd2;
    send_result(5'd20, 32'hA0);
    step();
    bus.dec_rd_addr_i = 5'd7;
    send_result(5'd21, 32'hA1);
    step();
    bus.issue_valid_i = 1'b0;
    bus.dec_rd_addr_i = 5'd0;
    bus.lsu_valid_i   = 1'b0;
    #1;
    n_checks++;
    if (bus.busy_o !== 32'h0000_0084)
      $display("FAIL pre_reset_busy got %h required %h", bus.busy_o, 32'h84);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy_o, bus.lsu_ready_o, bus.core_stall_o, bus.rf_wren_o, bus.rf_rd_addr_o} !==
        {32'd0, 3'b101, 5'd3})
      $display("FAIL midrun_reset got busy=%h rdy=%b stall=%b wren=%b addr=%0d required 0/1/0/1/3",
               bus.busy_o, bus.lsu_ready_o, bus.core_stall_o, bus.rf_wren_o, bus.rf_rd_addr_o);
    else n_pass++;
    core_write(1'b0);
    #1;
    n_checks++;
    if (bus.rf_wren_o !== 1'b0)
      $display("FAIL reset_wren_follows got %b required 0", bus.rf_wren_o);
    else n_pass++;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    #1;
    n_checks++;
    if (bus.rf_wren_o !== 1'b0)
      $display("FAIL reset_fifo_flushed got wren=%b required 0", bus.rf_wren_o);
    else n_pass++;
    step();
  endtask

  task automatic test_hazard();
    wr_t e;
    idle_inputs();
    bus.issue_valid_i = 1'b1;
    bus.dec_rd_addr_i = 5'd5;
    #1;
    n_checks++;
    if (bus.core_stall_o !== 1'b0)
      $display("FAIL hazard_issue_stall got %b required 0", bus.core_stall_o);
    else n_pass++;
    step();
    bus.issue_valid_i  = 1'b0;
    bus.dec_rd_addr_i  = 5'd0;
    bus.dec_rs1_addr_i = 5'd5;
    #1;
    n_checks++;
    if ({bus.core_stall_o, bus.busy_o} !== {1'b1, 32'h20})
      $display("FAIL hazard_rs1_stall got stall=%b busy=%h required 1/00000020",
               bus.core_stall_o, bus.busy_o);
    else n_pass++;
    step();
    step();
    send_result(5'd5, 32'hDEAD_BEEF);
    #1;
`ifdef RF_WB_BYPASS_EN
    e = exp_q.pop_front();
    n_checks++;
    if ({bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o, bus.core_stall_o} !==
        {1'b1, e.addr, e.data, 1'b1})
      $display("FAIL hazard_bypass_write got %b/%0d/%h stall=%b required 1/%0d/%h stall=1",
               bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o, bus.core_stall_o, e.addr, e.data);
    else n_pass++;
    step();
    bus.lsu_valid_i = 1'b0;
`else
    n_checks++;
    if ({bus.rf_wren_o, bus.core_stall_o} !== 2'b01)
      $display("FAIL hazard_accept_cycle got wren=%b stall=%b required 0/1",
               bus.rf_wren_o, bus.core_stall_o);
    else n_pass++;
    step();
    bus.lsu_valid_i = 1'b0;
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if ({bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o, bus.core_stall_o} !==
        {1'b1, e.addr, e.data, 1'b1})
      $display("FAIL hazard_result_write got %b/%0d/%h stall=%b required 1/%0d/%h stall=1",
               bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o, bus.core_stall_o, e.addr, e.data);
    else n_pass++;
    step();
`endif
    #1;
    n_checks++;
    if ({bus.core_stall_o, bus.busy_o} !== 33'd0)
      $display("FAIL hazard_release got stall=%b busy=%h required 0/0", bus.core_stall_o, bus.busy_o);
    else n_pass++;
    idle_inputs();
    step();
  endtask

  task automatic test_starvation();
    wr_t e;
    int  blocked = 0;
    bit  found   = 1'b0;
    idle_inputs();
    core_write(1'b1);
    send_result(5'd7, 32'h77);
    #1;
    n_checks++;
    if ({bus.rf_wren_o, bus.rf_rd_addr_o} !== {1'b1, 5'd3})
      $display("FAIL starve_core_wins got %b/%0d required 1/3", bus.rf_wren_o, bus.rf_rd_addr_o);
    else n_pass++;
    step();
    bus.lsu_valid_i = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (bus.rf_wren_o && bus.rf_rd_addr_o == 5'd7) found = 1'b1;
      else begin
        blocked++;
        step();
      end
    end
    n_checks++;
    if (!found || blocked != 8)
      $display("FAIL starve_blocked_cycles got found=%b blocked=%0d required 1/8", found, blocked);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if ({bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o, bus.core_stall_o} !==
        {1'b1, e.addr, e.data, 1'b1})
      $display("FAIL starve_force_cycle got %b/%0d/%h stall=%b required 1/%0d/%h stall=1",
               bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o, bus.core_stall_o, e.addr, e.data);
    else n_pass++;
    step();
    #1;
    n_checks++;
    if ({bus.rf_wren_o, bus.rf_rd_addr_o, bus.core_stall_o} !== {1'b1, 5'd3, 1'b0})
      $display("FAIL starve_core_retry got %b/%0d stall=%b required 1/3 stall=0",
               bus.rf_wren_o, bus.rf_rd_addr_o, bus.core_stall_o);
    else n_pass++;
    idle_inputs();
    step();
  endtask

  task automatic test_full();
    wr_t e;
    int  held      = 0;
    bit  saw_force = 1'b0;
    idle_inputs();
    core_write(1'b1);
    for (int i = 0; i < 4; i++) begin
      send_result(5'(10 + i), 32'h100 + 32'(i));
      step();
    end
    bus.lsu_valid_i   = 1'b1;
    bus.lsu_rd_addr_i = 5'd14;
    bus.lsu_rd_data_i = 32'h104;
    #1;
    n_checks++;
    if (bus.lsu_ready_o !== 1'b0)
      $display("FAIL full_ready_low got %b required 0", bus.lsu_ready_o);
    else n_pass++;
    for (int i = 0; i < 30 && bus.lsu_ready_o !== 1'b1; i++) begin
      if (bus.rf_wren_o && bus.rf_rd_addr_o == 5'd10) begin
        saw_force = 1'b1;
        e = exp_q.pop_front();
        n_checks++;
        if ({bus.rf_rd_data_o, bus.core_stall_o} !== {e.data, 1'b1})
          $display("FAIL full_force_pop got data=%h stall=%b required %h stall=1",
                   bus.rf_rd_data_o, bus.core_stall_o, e.data);
        else n_pass++;
      end
      held++;
      step();
      #1;
    end
    n_checks++;
    if ({saw_force, held} !== {1'b1, 32'd6})
      $display("FAIL full_hold got force=%b held=%0d required 1/6", saw_force, held);
    else n_pass++;
    send_result(5'd14, 32'h104);
    core_write(1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o} !== {1'b1, e.addr, e.data})
        $display("FAIL full_drain_%0d got %b/%0d/%h required 1/%0d/%h", i,
                 bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o, e.addr, e.data);
      else n_pass++;
      step();
      bus.lsu_valid_i = 1'b0;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_rd_zero();
    wr_t e;
    idle_inputs();
    bus.core_wren_i = 1'b1;
    send_result(5'd0, 32'h1234);
    #1;
    n_checks++;
    if ({bus.lsu_ready_o, bus.rf_wren_o} !== 2'b10)
      $display("FAIL rd0_core_x0 got rdy=%b wren=%b required 1/0", bus.lsu_ready_o, bus.rf_wren_o);
    else n_pass++;
    core_write(1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      send_result(5'(20 + i), 32'h200 + 32'(i));
      step();
    end
    bus.lsu_valid_i = 1'b0;
    #1;
    n_checks++;
    if (bus.lsu_ready_o !== 1'b1)
      $display("FAIL rd0_not_enqueued got rdy=%b required 1", bus.lsu_ready_o);
    else n_pass++;
    core_write(1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o} !== {1'b1, e.addr, e.data})
        $display("FAIL rd0_drain_%0d got %b/%0d/%h required 1/%0d/%h", i,
                 bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o, e.addr, e.data);
      else n_pass++;
      step();
    end
    #1;
    n_checks++;
    if (bus.rf_wren_o !== 1'b0)
      $display("FAIL rd0_no_extra_write got %b required 0", bus.rf_wren_o);
    else n_pass++;
    step();
  endtask

  task automatic test_bypass();
    wr_t e;
    idle_inputs();
    send_result(5'd9, 32'h99);
    #1;
`ifdef RF_WB_BYPASS_EN
    e = exp_q.pop_front();
    n_checks++;
    if ({bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o} !== {1'b1, e.addr, e.data})
      $display("FAIL bypass_same_cycle got %b/%0d/%h required 1/%0d/%h",
               bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o, e.addr, e.data);
    else n_pass++;
    step();
    bus.lsu_valid_i = 1'b0;
    #1;
    n_checks++;
    if (bus.rf_wren_o !== 1'b0)
      $display("FAIL bypass_not_enqueued got %b required 0", bus.rf_wren_o);
    else n_pass++;
`else
    n_checks++;
    if (bus.rf_wren_o !== 1'b0)
      $display("FAIL nobypass_same_cycle got %b required 0", bus.rf_wren_o);
    else n_pass++;
    step();
    bus.lsu_valid_i = 1'b0;
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if ({bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o} !== {1'b1, e.addr, e.data})
      $display("FAIL nobypass_next_cycle got %b/%0d/%h required 1/%0d/%h",
               bus.rf_wren_o, bus.rf_rd_addr_o, bus.rf_rd_data_o, e.addr, e.data);
    else n_pass++;
`endif
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_hazard();
    test_starvation();
    test_full();
    test_rd_zero();
    test_bypass();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_leftover got %0d required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between the core's single-cycle writeback and a long-latency unit (LSU/MDU) that returns results out of band.
- Buffers long-latency results in a small FIFO and keeps a per-register busy scoreboard.
- Raises a core stall on operand/destination hazards and on write-port starvation.
- Sits between core writeback, the long-latency unit and the 32x32 register file (x0 hardwired zero).

Parameters:
- DEPTH, 4, long-latency result FIFO entries (power of 2, >=2)
- MAX_WAIT, 8, consecutive cycles a non-empty FIFO may be blocked by core writes before a forced drain slot

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- core_wren_i  input  1  core writeback request this cycle
- core_rd_addr_i  input  5  core writeback destination
- core_rd_data_i  input  32  core writeback data
- lsu_valid_i  input  1  long-latency result valid
- lsu_ready_o  output  1  arbiter can accept result
- lsu_rd_addr_i  input  5  result destination
- lsu_rd_data_i  input  32  result data
- issue_valid_i  input  1  decoder issuing a long-latency op this cycle
- dec_rs1_addr_i  input  5  decoded rs1
- dec_rs2_addr_i  input  5  decoded rs2
- dec_rd_addr_i  input  5  decoded rd
- core_stall_o  output  1  core must hold the current instruction
- rf_wren_o  output  1  register file write enable
- rf_rd_addr_o  output  5  register file write address
- rf_rd_data_o  output  32  register file write data
- busy_o  output  32  scoreboard bit vector (bit 0 always 0)

Behaviour:
- Reset (async, rst_ni low): FIFO empty, busy_o=0, wait counter=0, state=NORMAL. Resulting outputs: lsu_ready_o=1, core_stall_o=0, rf_wren_o=core_wren_i. Reset mid-operation discards all FIFO contents and busy bits.
- FIFO handshake:
  - Push when lsu_valid_i && lsu_ready_o.
  - lsu_ready_o = !full; registered occupancy only, no same-cycle pop-through when full.
  - Entries with rd=0 are accepted and dropped: not enqueued, no write.
- Write-port arbitration (combinational mux, zero added latency):
  - NORMAL: core_wren_i && rd!=0 wins the port. Otherwise the FIFO head is written and popped if non-empty.
  - FORCE: FIFO head is written and popped; the core write is blocked (core_stall_o=1, core retries next cycle).
  - rf_wren_o is never asserted with rf_rd_addr_o=0.
- State machine:
  - Wait counter increments each cycle a non-empty FIFO loses to the core. It clears on any FIFO pop or when the FIFO is empty.
  - NORMAL->FORCE when counter==MAX_WAIT-1 and the FIFO is still blocked.
  - FORCE->NORMAL after exactly one cycle (one entry drained); counter clears.
- Scoreboard:
  - busy[rd] sets on issue_valid_i && !core_stall_o && rd!=0.
  - busy[rd] clears in the cycle that register's FIFO entry is written to the register file (visible next cycle).
  - Set and clear of different registers in the same cycle both take effect.
- Stall: core_stall_o = state==FORCE || busy[rs1] || busy[rs2] || busy[rd] (using registered busy bits).
  - A register written this cycle still stalls one cycle. This is conservative and intended.
  - Hazard stall guarantees at most one outstanding result per register.
- Illegal input: a result for a non-busy register is still written; the busy bit is unaffected.
- FIFO pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined: if the FIFO is empty, the port is not used by the core, state==NORMAL and lsu_valid_i is asserted, the result writes the register file in the same cycle. It is not enqueued, and the busy bit clears that cycle.
- Undefined: every result is enqueued; earliest register file write is the cycle after acceptance.

Test Plan:
- Reset with FIFO holding 2 entries and busy_o=0x0000_0084 -> busy_o=0, lsu_ready_o=1, rf_wren_o follows core_wren_i.
- Issue long-latency op rd=5; next cycle decode rs1=5 -> core_stall_o=1 until the result (rd=5, 0xDEADBEEF) is written, then 0 the following cycle; rf_rd_data_o=0xDEADBEEF.
- Core writes x3 every cycle while a result for x7 is queued -> exactly MAX_WAIT(8) blocked cycles, then one FORCE cycle: rf_rd_addr_o=7, core_stall_o=1, core write x3 deferred one cycle.
- Push 4 results with no drain (core writing every cycle, MAX_WAIT=8) -> lsu_ready_o=0 after the 4th; 5th held; first forced pop raises lsu_ready_o.
- Result with rd=0, data 0x1234 -> accepted, no rf_wren_o, FIFO occupancy unchanged.
- RF_WB_BYPASS_EN defined, idle core, empty FIFO, result rd=9 -> rf_wren_o=1, rf_rd_addr_o=9 in the same cycle. Undefined -> write one cycle later.
